// File: rtl/datapath_seq_ctrl.sv
// datapath_seq_ctrl
//   Handshake sequencer for the 4-operand datapath that computes
//   result = (A+B)-(C+D) mod 32. It accepts 4-bit operand words over a
//   valid/ready handshake and steers them, in order, onto the datapath
//   capture strobes A, B, C and D. It then pulses en so the datapath
//   latches its result, and pulses done on the following cycle.
//   The block owns no data path. The operand bus goes straight from the
//   source to the datapath, and this block only generates the strobes.
//
//   Optional feature (compile-time macro CTRL_TIMEOUT_EN):
//     When defined, a partially collected frame that sees TIMEOUT_CYCLES
//     idle cycles is dropped, and err pulses for one cycle.
//     When undefined, there is no timer, err is tied low, and a partial
//     frame waits indefinitely.
module datapath_seq_ctrl #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int TMR_W          = 4
) (
  input  logic clock,
  input  logic rst,
  input  logic valid,
  input  logic flush,
  output logic ready,
  output logic A,
  output logic B,
  output logic C,
  output logic D,
  output logic en,
  output logic busy,
  output logic done,
  output logic err
);

  // Controller states.
  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_CALC    = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam logic [1:0] LAST_SLOT  = 2'd3;

  logic [1:0] state_q, state_d;
  logic [1:0] idx_q,   idx_d;

  logic       accept;
  logic       timeout_hit;
  logic [3:0] slot_hit;

  // A word is taken only while collecting. A flush in the same cycle
  // kills the transfer, so no strobe reaches the datapath.
  assign accept = valid & ready & ~flush;

  // Per-slot strobe decode. Exactly one slot fires per accepted word,
  // chosen by the current slot index.
  for (genvar gi = 0; gi < 4; gi++) begin : g_slot
    assign slot_hit[gi] = accept & (idx_q == 2'(gi));
  end

  assign A = slot_hit[0];
  assign B = slot_hit[1];
  assign C = slot_hit[2];
  assign D = slot_hit[3];

  // Status outputs are decoded directly from the registered state.
  always_comb begin
    ready = (state_q == ST_COLLECT);
    en    = (state_q == ST_CALC);
    done  = (state_q == ST_DONE);
    busy  = (idx_q != 2'd0) || (state_q != ST_COLLECT);
  end

`ifdef CTRL_TIMEOUT_EN
  logic [TMR_W-1:0] timer_q, timer_d;

  // The timer only runs while a frame is partially collected. An accept
  // in the expiry cycle takes priority, and the word is kept.
  assign timeout_hit = (state_q == ST_COLLECT) && (idx_q != 2'd0) &&
                       !accept && !flush &&
                       (timer_q == TMR_W'(TIMEOUT_CYCLES));

  assign err = timeout_hit;

  // Idle-cycle counter for a partial frame. It clears on any accept,
  // on expiry, on flush, and whenever no frame is pending.
  always_comb begin
    timer_d = timer_q;
    if (flush) begin
      timer_d = '0;
    end else if ((state_q == ST_COLLECT) && (idx_q != 2'd0)) begin
      if (accept || timeout_hit) begin
        timer_d = '0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end else begin
      timer_d = '0;
    end
  end

  // Timer register.
  always_ff @(posedge clock) begin
    if (rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // Next-state and slot-index logic. Flush overrides every other update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_COLLECT: begin
        if (accept) begin
          if (idx_q == LAST_SLOT) begin
            idx_d   = 2'd0;
            state_d = ST_CALC;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else if (timeout_hit) begin
          idx_d = 2'd0;
        end
      end
      ST_CALC: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_COLLECT;
      end
      default: begin
        state_d = ST_COLLECT;
        idx_d   = 2'd0;
      end
    endcase
    if (flush) begin
      state_d = ST_COLLECT;
      idx_d   = 2'd0;
    end
  end

  // State and index registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= ST_COLLECT;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_datapath_seq_ctrl.sv
// tb_datapath_seq_ctrl
//   Table-driven vectors with a result scoreboard. A behavioural datapath,
//   driven by the DUT strobes, holds the operands and the result. Expected
//   results are queued when a frame's last word is driven, and they are
//   checked whenever done is high.
module tb_datapath_seq_ctrl;

  logic clock = 1'b0;
  logic rst, valid, flush;
  logic ready, A, B, C, D, en, busy, done, err;
  logic [3:0] din;

  always #5 clock = ~clock;

  datapath_seq_ctrl dut (
    .clock (clock),
    .rst   (rst),
    .valid (valid),
    .flush (flush),
    .ready (ready),
    .A     (A),
    .B     (B),
    .C     (C),
    .D     (D),
    .en    (en),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  // Output vector bit masks: {ready,A,B,C,D,en,done,busy,err}.
  localparam logic [8:0] O_RDY  = 9'b1_0000_0000;
  localparam logic [8:0] O_A    = 9'b0_1000_0000;
  localparam logic [8:0] O_B    = 9'b0_0100_0000;
  localparam logic [8:0] O_C    = 9'b0_0010_0000;
  localparam logic [8:0] O_D    = 9'b0_0001_0000;
  localparam logic [8:0] O_EN   = 9'b0_0000_1000;
  localparam logic [8:0] O_DONE = 9'b0_0000_0100;
  localparam logic [8:0] O_BUSY = 9'b0_0000_0010;
  localparam logic [8:0] O_ERR  = 9'b0_0000_0001;

  typedef struct {
    logic       valid;
    logic       flush;
    logic [3:0] din;
    logic [8:0] exp;
    logic       push;
    logic [4:0] res;
  } vec_t;

  vec_t       vecs[$];
  logic [4:0] sb[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  // Behavioural datapath: operand capture on the strobes, result on en.
  logic [3:0] a_r, b_r, c_r, d_r;
  logic [4:0] res_r;
  always @(posedge clock) begin
    if (A)  a_r <= din;
    if (B)  b_r <= din;
    if (C)  c_r <= din;
    if (D)  d_r <= din;
    if (en) res_r <= ({1'b0, a_r} + {1'b0, b_r}) - ({1'b0, c_r} + {1'b0, d_r});
  end

  function automatic logic [8:0] outs();
    return {ready, A, B, C, D, en, done, busy, err};
  endfunction

  function automatic vec_t mk(logic v, logic f, logic [3:0] d, logic [8:0] e,
                              logic p, logic [4:0] r);
    vec_t t;
    t.valid = v; t.flush = f; t.din = d; t.exp = e; t.push = p; t.res = r;
    return t;
  endfunction

  task automatic check(string name, logic [8:0] got, logic [8:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %0s outs=%b", name, got);
    end else begin
      $display("FAIL %0s outs got=%b expected=%b", name, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, check the outputs, then advance one clock.
  task automatic apply(vec_t v, string name);
    valid = v.valid;
    flush = v.flush;
    din   = v.din;
    #1;
    check(name, outs(), v.exp);
    if (v.push) sb.push_back(v.res);
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: each done pulse must match the oldest queued result.
  always @(negedge clock) begin
    if (!rst && done) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL result unexpected done got=%0d expected=no done", res_r);
      end else begin
        logic [4:0] e;
        e = sb.pop_front();
        if (res_r === e) begin
          n_pass++;
          $display("ok   result got=%0d", res_r);
        end else begin
          $display("FAIL result got=%0d expected=%0d", res_r, e);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst = 1'b1; valid = 1'b0; flush = 1'b0; din = 4'd0;
    repeat (2) @(posedge clock);
    #1;
    rst = 1'b0;
    #1;
    check("reset", outs(), O_RDY);

    // Frame 3,5,2,1 -> 5
    vecs.push_back(mk(1, 0, 4'd3, O_RDY | O_A,          0, 5'd0));
    vecs.push_back(mk(1, 0, 4'd5, O_RDY | O_B | O_BUSY, 0, 5'd0));
    vecs.push_back(mk(1, 0, 4'd2, O_RDY | O_C | O_BUSY, 0, 5'd0));
    vecs.push_back(mk(1, 0, 4'd1, O_RDY | O_D | O_BUSY, 1, 5'd5));
    vecs.push_back(mk(0, 0, 4'd0, O_EN | O_BUSY,        0, 5'd0));
    vecs.push_back(mk(0, 0, 4'd0, O_DONE | O_BUSY,      0, 5'd0));
    // Frame 1,1,7,7 -> 20, then back-to-back frame 4,4,0,0 -> 8 with valid held
    vecs.push_back(mk(1, 0, 4'd1, O_RDY | O_A,          0, 5'd0));
    vecs.push_back(mk(1, 0, 4'd1, O_RDY | O_B | O_BUSY, 0, 5'd0));
    vecs.push_back(mk(1, 0, 4'd7, O_RDY | O_C | O_BUSY, 0, 5'd0));
    vecs.push_back(mk(1, 0, 4'd7, O_RDY | O_D | O_BUSY, 1, 5'd20));
    vecs.push_back(mk(1, 0, 4'd4, O_EN | O_BUSY,        0, 5'd0));
    vecs.push_back(mk(1, 0, 4'd4, O_DONE | O_BUSY,      0, 5'd0));
    vecs.push_back(mk(1, 0, 4'd4, O_RDY | O_A,          0, 5'd0));
    vecs.push_back(mk(1, 0, 4'd4, O_RDY | O_B | O_BUSY, 0, 5'd0));
    vecs.push_back(mk(1, 0, 4'd0, O_RDY | O_C | O_BUSY, 0, 5'd0));
    vecs.push_back(mk(1, 0, 4'd0, O_RDY | O_D | O_BUSY, 1, 5'd8));
    vecs.push_back(mk(1, 0, 4'd9, O_EN | O_BUSY,        0, 5'd0));
    vecs.push_back(mk(1, 0, 4'd9, O_DONE | O_BUSY,      0, 5'd0));
    vecs.push_back(mk(0, 0, 4'd0, O_RDY,                0, 5'd0));
    // Flush together with valid after A,B; then 6,6,1,1 -> 10
    vecs.push_back(mk(1, 0, 4'd9, O_RDY | O_A,          0, 5'd0));
    vecs.push_back(mk(1, 0, 4'd9, O_RDY | O_B | O_BUSY, 0, 5'd0));
    vecs.push_back(mk(1, 1, 4'd3, O_RDY | O_BUSY,       0, 5'd0));
    vecs.push_back(mk(1, 0, 4'd6, O_RDY | O_A,          0, 5'd0));
    vecs.push_back(mk(1, 0, 4'd6, O_RDY | O_B | O_BUSY, 0, 5'd0));
    vecs.push_back(mk(1, 0, 4'd1, O_RDY | O_C | O_BUSY, 0, 5'd0));
    vecs.push_back(mk(1, 0, 4'd1, O_RDY | O_D | O_BUSY, 1, 5'd10));
    vecs.push_back(mk(0, 0, 4'd0, O_EN | O_BUSY,        0, 5'd0));
    vecs.push_back(mk(0, 0, 4'd0, O_DONE | O_BUSY,      0, 5'd0));
    vecs.push_back(mk(0, 0, 4'd0, O_RDY,                0, 5'd0));
    // Flush during CALC: en still pulses, done suppressed
    vecs.push_back(mk(1, 0, 4'd2, O_RDY | O_A,          0, 5'd0));
    vecs.push_back(mk(1, 0, 4'd2, O_RDY | O_B | O_BUSY, 0, 5'd0));
    vecs.push_back(mk(1, 0, 4'd2, O_RDY | O_C | O_BUSY, 0, 5'd0));
    vecs.push_back(mk(1, 0, 4'd2, O_RDY | O_D | O_BUSY, 0, 5'd0));
    vecs.push_back(mk(0, 1, 4'd0, O_EN | O_BUSY,        0, 5'd0));
    vecs.push_back(mk(0, 0, 4'd0, O_RDY,                0, 5'd0));
    // Flush during DONE: done still pulses; 3,3,3,3 -> 0
    vecs.push_back(mk(1, 0, 4'd3, O_RDY | O_A,          0, 5'd0));
    vecs.push_back(mk(1, 0, 4'd3, O_RDY | O_B | O_BUSY, 0, 5'd0));
    vecs.push_back(mk(1, 0, 4'd3, O_RDY | O_C | O_BUSY, 0, 5'd0));
    vecs.push_back(mk(1, 0, 4'd3, O_RDY | O_D | O_BUSY, 1, 5'd0));
    vecs.push_back(mk(0, 0, 4'd0, O_EN | O_BUSY,        0, 5'd0));
    vecs.push_back(mk(0, 1, 4'd0, O_DONE | O_BUSY,      0, 5'd0));
    vecs.push_back(mk(0, 0, 4'd0, O_RDY,                0, 5'd0));

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted during CALC: 1,2,3,4 never completes
    apply(mk(1, 0, 4'd1, O_RDY | O_A,          0, 5'd0), "rst_a");
    apply(mk(1, 0, 4'd2, O_RDY | O_B | O_BUSY, 0, 5'd0), "rst_b");
    apply(mk(1, 0, 4'd3, O_RDY | O_C | O_BUSY, 0, 5'd0), "rst_c");
    apply(mk(1, 0, 4'd4, O_RDY | O_D | O_BUSY, 0, 5'd0), "rst_d");
    valid = 1'b0;
    rst   = 1'b1;
    #1;
    check("rst_calc_en", outs(), O_EN | O_BUSY);
    @(posedge clock);
    #1;
    rst = 1'b0;
    #1;
    check("rst_after", outs(), O_RDY);
    @(posedge clock);
    #1;
    check("rst_after2", outs(), O_RDY);
    // Frame 7,7,1,0 -> 13, with a bounded wait for done
    apply(mk(1, 0, 4'd7, O_RDY | O_A,          0, 5'd0),  "post_a");
    apply(mk(1, 0, 4'd7, O_RDY | O_B | O_BUSY, 0, 5'd0),  "post_b");
    apply(mk(1, 0, 4'd1, O_RDY | O_C | O_BUSY, 0, 5'd0),  "post_c");
    apply(mk(1, 0, 4'd0, O_RDY | O_D | O_BUSY, 1, 5'd13), "post_d");
    valid = 1'b0;
    seen  = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      #1;
      if (done) seen = 1'b1;
      @(posedge clock);
      #1;
    end
    n_checks++;
    if (seen) n_pass++;
    else $display("FAIL post_rst_done got=no done expected=done within 10 cycles");

    // Partial frame left idle: timeout abort or indefinite wait
    apply(mk(1, 0, 4'd5, O_RDY | O_A, 0, 5'd0), "tmo_a");
    for (int k = 0; k < 20; k++) begin
      logic [8:0] e;
`ifdef CTRL_TIMEOUT_EN
      e = O_RDY | ((k <= 15) ? O_BUSY : 9'd0) | ((k == 15) ? O_ERR : 9'd0);
`else
      e = O_RDY | O_BUSY;
`endif
      apply(mk(0, 0, 4'd0, e, 0, 5'd0), $sformatf("tmo_idle%0d", k));
    end
`ifdef CTRL_TIMEOUT_EN
    apply(mk(0, 1, 4'd0, O_RDY, 0, 5'd0), "tmo_flush");
`else
    apply(mk(0, 1, 4'd0, O_RDY | O_BUSY, 0, 5'd0), "tmo_flush");
`endif
    // Fresh frame 2,5,3,1 -> 3
    apply(mk(1, 0, 4'd2, O_RDY | O_A,          0, 5'd0), "fresh_a");
    apply(mk(1, 0, 4'd5, O_RDY | O_B | O_BUSY, 0, 5'd0), "fresh_b");
    apply(mk(1, 0, 4'd3, O_RDY | O_C | O_BUSY, 0, 5'd0), "fresh_c");
    apply(mk(1, 0, 4'd1, O_RDY | O_D | O_BUSY, 1, 5'd3), "fresh_d");
    apply(mk(0, 0, 4'd0, O_EN | O_BUSY,        0, 5'd0), "fresh_en");
    apply(mk(0, 0, 4'd0, O_DONE | O_BUSY,      0, 5'd0), "fresh_done");
    apply(mk(0, 0, 4'd0, O_RDY,                0, 5'd0), "fresh_idle");

    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL sb_drain got=%0d pending expected=0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
